// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key length encodings, Nk/Nr lookup, storage sizing, xtime.
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128  = 2'b00;
    localparam logic [1:0] KEY_LEN_192  = 2'b01;
    localparam logic [1:0] KEY_LEN_256  = 2'b10;
    localparam logic [1:0] KEY_LEN_RSVD = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GEN  = 1'b1
    } ks_state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: return 4'd4;
            KEY_LEN_192: return 4'd6;
            KEY_LEN_256: return 4'd8;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: return 4'd10;
            KEY_LEN_192: return 4'd12;
            KEY_LEN_256: return 4'd14;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic int max_words(input int max_nr);
        return 4 * (max_nr + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box, purely combinational byte lookup.
module sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so entry a starts at bit 8*(255-a).
    logic [10:0] w_lsb;
    assign w_lsb  = {~i_byte, 3'b000};
    assign o_byte = SBOX_TAB[w_lsb +: 8];

endmodule

// File: rtl/sub_word.sv
// 32-bit AES SubWord: four parallel S-box lookups, combinational.
module sub_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox u_sbox (
            .i_byte (i_word[8*g +: 8]),
            .o_byte (o_word[8*g +: 8])
        );
    end

endmodule

// File: rtl/key_schedule.sv
// AES-128/192/256 key expansion, one word per cycle after the start edge; done after 40/46/52 edges.
// No backpressure: starts while busy are dropped, illegal starts pulse err; rd_key is registered.
module key_schedule
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [1:0]            i_key_len,
    input  logic [32*MAX_NK-1:0]  i_key_in,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_keys_valid,
    input  logic [3:0]            i_rd_round,
    output logic [127:0]          o_rd_key
);

    localparam int MAX_NR = MAX_NK + 6;
    localparam int NW     = max_words(MAX_NR);
    localparam int IW     = $clog2(NW);

    ks_state_t     r_state, w_state_nxt;
    logic [31:0]   r_w [NW];
    logic [IW-1:0] r_i;
    logic [2:0]    r_pos;
    logic [3:0]    r_nk, r_nr;
    logic [7:0]    r_rcon;
    logic          r_done, r_err, r_keys_valid;
    logic [127:0]  r_rd_key;

    logic [3:0]    w_nk_in;
    logic          w_legal, w_accept, w_reject, w_gen, w_last;
    logic [IW-1:0] w_last_idx, w_rd_base;
    logic [31:0]   w_prev, w_old, w_sw_in, w_sw_out, w_temp, w_new;

    assign w_nk_in    = nk_of(i_key_len);
    assign w_legal    = (i_key_len != KEY_LEN_RSVD) && (int'(w_nk_in) <= MAX_NK);
    assign w_accept   = i_start && (r_state == S_IDLE) && w_legal;
    assign w_reject   = i_start && (r_state == S_IDLE) && !w_legal;
    assign w_gen      = (r_state == S_GEN);
    assign w_last_idx = IW'({r_nr, 2'b11});
    assign w_last     = w_gen && (r_i == w_last_idx);

    // r_pos tracks i mod Nk so no divider is needed.
    assign w_prev  = r_w[r_i - IW'(1)];
    assign w_old   = r_w[r_i - IW'(r_nk)];
    assign w_sw_in = (r_pos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    sub_word u_sub_word (
        .i_word (w_sw_in),
        .o_word (w_sw_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_pos == 3'd0)
            w_temp = w_sw_out ^ {r_rcon, 24'h0};
        else if ((r_nk == 4'd8) && (r_pos == 3'd4))
            w_temp = w_sw_out;
    end

    assign w_new = w_old ^ w_temp;

    always_ff @(posedge clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_GEN;
            S_GEN:   if (w_last)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == S_GEN);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_i          <= '0;
            r_pos        <= '0;
            r_nk         <= '0;
            r_nr         <= '0;
            r_rcon       <= 8'h01;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= w_last;
            r_err  <= w_reject;
            if (w_accept) begin
                r_nk         <= w_nk_in;
                r_nr         <= nr_of(i_key_len);
                r_i          <= IW'(w_nk_in);
                r_pos        <= '0;
                r_rcon       <= 8'h01;
                r_keys_valid <= 1'b0;
            end else if (w_gen) begin
                r_i   <= r_i + IW'(1);
                r_pos <= ({1'b0, r_pos} == r_nk - 4'd1) ? 3'd0 : r_pos + 3'd1;
                if (r_pos == 3'd0)
                    r_rcon <= xtime(r_rcon);
                if (w_last)
                    r_keys_valid <= 1'b1;
            end
        end
    end

    // Storage is never cleared; keys_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            if (w_accept) begin
                for (int j = 0; j < MAX_NK; j++) begin
                    if (j < int'(w_nk_in))
                        r_w[j] <= i_key_in[32*(MAX_NK-j)-1 -: 32];
                end
            end else if (w_gen) begin
                r_w[r_i] <= w_new;
            end
        end
    end

    assign w_rd_base = IW'({i_rd_round, 2'b00});

    always_ff @(posedge clk) begin
        if (i_rst || !r_keys_valid || w_accept || (i_rd_round > r_nr))
            r_rd_key <= '0;
        else
            r_rd_key <= {r_w[w_rd_base], r_w[w_rd_base + IW'(1)],
                         r_w[w_rd_base + IW'(2)], r_w[w_rd_base + IW'(3)]};
    end

    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_keys_valid = r_keys_valid;
    assign o_rd_key     = r_rd_key;

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule: FIPS-197 vectors, rejected/ignored starts, reset abort, read bounds.
module tb_key_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, busy, done, err, keys_valid;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;

    logic         s_rst, s_start, s_busy, s_done, s_err, s_keys_valid;
    logic [1:0]   s_key_len;
    logic [127:0] s_key_in;
    logic [3:0]   s_rd_round;
    logic [127:0] s_rd_key;

    key_schedule #(.MAX_NK(8)) dut (
        .clk(clk), .i_rst(rst), .i_start(start), .i_key_len(key_len), .i_key_in(key_in),
        .o_busy(busy), .o_done(done), .o_err(err), .o_keys_valid(keys_valid),
        .i_rd_round(rd_round), .o_rd_key(rd_key)
    );

    key_schedule #(.MAX_NK(4)) dut4 (
        .clk(clk), .i_rst(s_rst), .i_start(s_start), .i_key_len(s_key_len), .i_key_in(s_key_in),
        .o_busy(s_busy), .o_done(s_done), .o_err(s_err), .o_keys_valid(s_keys_valid),
        .i_rd_round(s_rd_round), .o_rd_key(s_rd_key)
    );

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [1:0]   len;
        logic [255:0] key;
        int           lat;
        logic [3:0]   rnd;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[9];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] len, input logic [255:0] key, output int lat);
        key_len = len;
        key_in  = key;
        start   = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic read_round(input logic [3:0] r, output logic [127:0] val);
        rd_round = r;
        tick();
        val = rd_key;
    endtask

    initial begin
        int           lat;
        logic [127:0] val;

        vecs[0] = '{2'b00, K128, 40, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{2'b00, K128, 40, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{2'b00, K128, 40, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{2'b01, K192, 46, 4'd0,  128'h8e73b0f7da0e6452c810f32b809079e5};
        vecs[4] = '{2'b01, K192, 46, 4'd12, 128'he98ba06f448c773c8ecc720401002202};
        vecs[5] = '{2'b10, K256, 52, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
        vecs[6] = '{2'b10, K256, 52, 4'd1,  128'h1f352c073b6108d72d9810a30914dff4};
        vecs[7] = '{2'b10, K256, 52, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[8] = '{2'b00, K128, 40, 4'd11, 128'h0};

        rst = 1'b1; start = 1'b1; key_len = 2'b00; key_in = K128; rd_round = 4'd0;
        s_rst = 1'b1; s_start = 1'b0; s_key_len = 2'b00; s_key_in = K128[255:128]; s_rd_round = 4'd0;
        tick();
        tick();
        rst = 1'b0; start = 1'b0; s_rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_keys_valid", keys_valid, 0);
        check("reset_rd_key", rd_key, 0);

        for (int v = 0; v < 9; v++) begin
            run(vecs[v].len, vecs[v].key, lat);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d_keys_valid", v), keys_valid, 1);
            read_round(vecs[v].rnd, val);
            check($sformatf("vec%0d_round%0d", v, vecs[v].rnd), val, vecs[v].exp);
        end

        key_len = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        check("rsvd_err_pulse", err, 1);
        check("rsvd_busy", busy, 0);
        check("rsvd_keys_valid", keys_valid, 1);
        tick();
        check("rsvd_err_clears", err, 0);

        rd_round = 4'd0; key_len = 2'b00; key_in = K128; start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_keys_valid_drop", keys_valid, 0);
        check("restart_busy", busy, 1);
        tick();
        check("restart_rd_key_zero", rd_key, 0);
        tick(); tick(); tick();
        key_len = 2'b10; key_in = K256; start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_no_err", err, 0);
        lat = 5;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        check("busy_start_latency", lat, 40);
        read_round(4'd10, val);
        check("busy_start_round10", val, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        key_len = 2'b10; key_in = K256; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_keys_valid", keys_valid, 0);
        read_round(4'd0, val);
        check("abort_round0", val, 0);
        run(2'b00, K128, lat);
        check("after_abort_latency", lat, 40);
        read_round(4'd1, val);
        check("after_abort_round1", val, 128'ha0fafe1788542cb123a339392a6c7605);
        read_round(4'd11, val);
        check("after_abort_round11", val, 0);

        s_key_len = 2'b10; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("nk4_aes256_err", s_err, 1);
        check("nk4_aes256_busy", s_busy, 0);
        s_key_len = 2'b00; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("nk4_aes128_busy", s_busy, 1);
        lat = 0;
        while (!s_done && lat < 200) begin
            tick();
            lat++;
        end
        check("nk4_aes128_latency", lat, 40);
        s_rd_round = 4'd10;
        tick();
        check("nk4_round10", s_rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
